// File: rtl/uart_dev.sv
// uart_dev: memory-mapped 8N1 serial port on the core data bus.
// Four-word register window at BASE: TXDATA, STATUS, RXDATA, reserved.
module uart_dev #(
  parameter logic [31:0] BASE   = 32'h20,
  parameter int          CLKDIV = 16,
  parameter int          DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        txd,
  input  logic        rxd
);

  localparam int CW   = $clog2(CLKDIV);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_st_e;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_e;

  logic        sel;
  logic [1:0]  rsel;
  logic [31:0] rdata;
  logic        push, pop, full, empty, tx_idle, clr;
  logic        unused_hi;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] fcnt_q, fcnt_d;

  tx_st_e        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;
  logic          tx_end;

  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rs1_q, rs2_q, rprev_q;
  logic          rx_end, rx_half, done;

  assign sel       = addr[31:2] == BASE[31:2];
  assign rsel      = addr[1:0];
  assign unused_hi = ^data[31:8];
  assign full      = fcnt_q == CNTW'(DEPTH);
  assign empty     = fcnt_q == '0;
  assign tx_idle   = empty && (tx_st_q == T_IDLE);
  assign push      = strobe && sel && rw && (rsel == 2'd0) && !full;
  assign clr       = strobe && sel && !rw && (rsel == 2'd2);
  assign tx_end    = tx_cnt_q == CW'(CLKDIV - 1);
  assign rx_end    = rx_cnt_q == CW'(CLKDIV - 1);
  assign rx_half   = rx_cnt_q == CW'(CLKDIV / 2 - 1);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (rsel == 2'd1): rdata = {28'b0, rx_ovr_q, rx_valid_q, tx_idle, full};
      (rsel == 2'd2): rdata = {24'b0, rx_byte_q};
      default:        rdata = '0;
    endcase
  end

  assign data = (sel && !rw) ? rdata : 32'bz;
  assign txd  = txd_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data[7:0];
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + CW'(1);
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    pop      = 1'b0;
    unique case (tx_st_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          tx_sh_d = mem_q[rd_q];
          tx_st_d = T_START;
        end
      end
      T_START: if (tx_end) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d  = T_DATA;
      end
      T_DATA: if (tx_end) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = T_STOP;
      end
      T_STOP: if (tx_end) begin
        tx_cnt_d = '0;
        // back-to-back frames: reload straight from the FIFO
        if (!empty) begin
          pop     = 1'b1;
          tx_sh_d = mem_q[rd_q];
          tx_st_d = T_START;
        end else begin
          tx_st_d = T_IDLE;
        end
      end
      default: tx_st_d = T_IDLE;
    endcase
    unique case (tx_st_d)
      T_START: txd_d = 1'b0;
      T_DATA:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
    wr_d   = wr_q + AW'(push);
    rd_d   = rd_q + AW'(pop);
    fcnt_d = fcnt_q + CNTW'(push) - CNTW'(pop);
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + CW'(1);
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    done     = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = CW'(1);
        if (!rs2_q && rprev_q) rx_st_d = R_START;
      end
      R_START: if (rx_half) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rs2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rs2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end
      R_STOP: if (rx_end) begin
        rx_st_d = R_IDLE;
        done    = rs2_q;
      end
      default: rx_st_d = R_IDLE;
    endcase
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    // a completing frame beats a same-edge read clear
    if (done && (!rx_valid_q || clr)) begin
      rx_byte_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      rx_ovr_d   = 1'b0;
    end else if (done) begin
      rx_ovr_d   = 1'b1;
    end else if (clr) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
      tx_st_q    <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rs1_q      <= 1'b1;
      rs2_q      <= 1'b1;
      rprev_q    <= 1'b1;
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fcnt_q     <= fcnt_d;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rs1_q      <= rxd;
      rs2_q      <= rs1_q;
      rprev_q    <= rs2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_dev.sv
// tb_uart_dev: randomized bench for uart_dev against a
// frame-level model of the serial port and register map.
module tb_uart_dev;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        strobe = 0;
  logic        rw = 0;
  logic        rxd = 1;
  logic        drv_en = 0;
  logic [31:0] addr = 0;
  logic [31:0] drv_val = 0;
  logic        txd;
  tri1  [31:0] data;

  assign data = drv_en ? drv_val : 32'bz;

  uart_dev #(.BASE(32'h20), .CLKDIV(C), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .rw(rw),
    .addr(addr), .data(data), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0;
  int n_fail = 0;
  int k_first = 0;
  int rx_c0 = 0;

  logic [7:0] m_byte = 0;
  bit         m_valid = 0;
  bit         m_ovr = 0;
  logic [7:0] burst[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_frame(input logic [7:0] b,
                                  input bit ok, input bit clr);
    if (!ok) return;
    if (!m_valid || clr) begin
      m_byte = b; m_valid = 1; m_ovr = 0;
    end else begin
      m_ovr = 1;
    end
  endfunction

  function automatic logic [31:0] m_status(input bit full,
                                           input bit idle);
    return {28'b0, m_ovr, m_valid, idle, full};
  endfunction

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v,
                        output int k);
    @(negedge clk);
    addr = a; rw = 1; drv_en = 1; drv_val = v; strobe = 1;
    @(posedge clk);
    #1;
    k = cyc; strobe = 0; drv_en = 0; rw = 0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input bit s,
                        output logic [31:0] v);
    @(negedge clk);
    addr = a; rw = 0; drv_en = 0; strobe = s;
    #1;
    v = data;
    if (s) begin
      @(posedge clk);
      #1;
      strobe = 0;
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input int j);
    logic [9:0] f;
    int t, bad;
    f = {1'b1, b, 1'b0};
    t = -1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin t = cyc; break; end
    end
    check("tx_start", t, k_first + 1 + 10 * C * j);
    if (t >= 0)
      for (int i = 1; i < 10 * C; i++) begin
        @(negedge clk);
        if (txd !== f[i / C]) bad++;
      end
    check("tx_bits", bad, 0);
  endtask

  task automatic run_burst();
    logic [7:0] mq[$], ex[$];
    logic [31:0] st;
    bit busy, full;
    int k;
    busy = 0;
    foreach (burst[i]) begin
      full = mq.size() == DEPTH;
      if (!busy && mq.size() > 0) begin
        ex.push_back(mq.pop_front());
        busy = 1;
      end
      if (!full) mq.push_back(burst[i]);
    end
    full = mq.size() == DEPTH;
    foreach (mq[i]) ex.push_back(mq[i]);
    fork
      begin
        foreach (burst[i]) begin
          bus_wr(32'h20, {24'b0, burst[i]}, k);
          if (i == 0) k_first = k;
        end
        bus_rd(32'h21, 0, st);
        check("burst_status", st, {31'b0, full});
      end
      begin
        foreach (ex[j]) tx_frame(ex[j], j);
      end
    join
    bus_rd(32'h21, 0, st);
    check("burst_idle", st, m_status(0, 1));
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) rx_c0 = cyc;
      rxd = f[i];
      repeat (C - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_check(input string tag);
    logic [31:0] v;
    bus_rd(32'h21, 0, v);
    check({tag, "_status"}, v, m_status(0, 1));
    bus_rd(32'h22, 0, v);
    check({tag, "_data"}, v, {24'b0, m_byte});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: cycle %0d reached, limit exceeded", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int k, t, lows;
    logic [7:0] b;
    bit ok, rd;

    repeat (3) @(negedge clk);
    reset_n = 1;
    check("rst_txd", {31'b0, txd}, 32'h1);
    bus_rd(32'h21, 0, v); check("rst_status", v, 32'h2);
    bus_rd(32'h22, 0, v); check("rst_rxdata", v, 32'h0);
    bus_rd(32'h20, 0, v); check("txdata_load", v, 32'h0);
    bus_rd(32'h23, 1, v); check("reserved_load", v, 32'h0);
    bus_rd(32'h40, 0, v); check("z_far", v, 32'hFFFF_FFFF);
    bus_rd(32'h1F, 0, v); check("z_below", v, 32'hFFFF_FFFF);
    @(negedge clk);
    addr = 32'h21; rw = 1; drv_en = 0; strobe = 0;
    #1;
    check("z_store", data, 32'hFFFF_FFFF);
    rw = 0;
    bus_wr(32'h23, 32'hAB, k);
    bus_rd(32'h21, 0, v); check("reserved_store", v, 32'h2);

    bus_wr(32'h20, 32'h55, k);
    k_first = k;
    tx_frame(8'h55, 0);
    bus_rd(32'h21, 0, v); check("single_status", v, 32'h2);

    burst = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_burst();
    for (int r = 0; r < 3; r++) begin
      burst = {};
      repeat ($urandom_range(1, 7)) burst.push_back(8'($urandom));
      run_burst();
    end
    lows = 0;
    repeat (50) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    check("tx_quiet", lows, 0);

    t = -1;
    rx_c0 = -100000;
    fork
      send_rx(8'hA3, 1);
      for (int i = 0; i < 400; i++) begin
        bus_rd(32'h21, 0, v);
        if (v[2]) begin t = cyc - rx_c0; break; end
      end
    join
    check("rx_latency", t, 2 + H + 9 * C);
    m_frame(8'hA3, 1, 0);
    rx_check("rx_a3");
    bus_rd(32'h22, 1, v); check("rx_a3_load", v, 32'hA3);
    m_valid = 0; m_ovr = 0;
    rx_check("rx_a3_clr");

    send_rx(8'h11, 1); m_frame(8'h11, 1, 0);
    send_rx(8'h22, 1); m_frame(8'h22, 1, 0);
    rx_check("overrun");
    bus_rd(32'h22, 1, v); check("overrun_load", v, 32'h11);
    m_valid = 0; m_ovr = 0;
    rx_check("overrun_clr");

    @(negedge clk); rxd = 0;
    repeat (4) @(negedge clk); rxd = 1;
    repeat (2 * C) @(negedge clk);
    rx_check("false_start");
    send_rx(8'h3C, 0); m_frame(8'h3C, 0, 0);
    rx_check("bad_stop");

    for (int r = 0; r < 8; r++) begin
      b = 8'($urandom);
      ok = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, 1) == 1;
      send_rx(b, ok);
      m_frame(b, ok, 0);
      rx_check("rx_rand");
      if (rd) begin
        bus_rd(32'h22, 1, v);
        check("rx_rand_load", v, {24'b0, m_byte});
        m_valid = 0; m_ovr = 0;
      end
    end

    send_rx(8'h5A, 1); m_frame(8'h5A, 1, 0);
    send_rx(8'h66, 1); m_frame(8'h66, 1, 0);
    t = -1;
    rx_c0 = -100000;
    fork
      send_rx(8'hC3, 1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk); #1;
          if (cyc == rx_c0 + 1 + H + 9 * C) begin t = i; break; end
        end
        if (t >= 0) begin
          bus_rd(32'h22, 1, v);
          check("race_load", v, {24'b0, m_byte});
        end
      end
    join
    check("race_sync", {31'b0, t >= 0}, 32'h1);
    m_frame(8'hC3, 1, 1);
    rx_check("race");

    bus_wr(32'h20, 32'h00, k);
    bus_wr(32'h20, 32'hFF, k);
    repeat (40) @(negedge clk);
    check("pre_reset_txd", {31'b0, txd}, 32'h0);
    @(negedge clk);
    reset_n = 0;
    #1;
    check("reset_txd", {31'b0, txd}, 32'h1);
    repeat (3) @(negedge clk);
    reset_n = 1;
    m_valid = 0; m_ovr = 0; m_byte = 0;
    bus_rd(32'h21, 0, v); check("reset_status", v, 32'h2);
    lows = 0;
    repeat (12 * C) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    check("reset_flush", lows, 0);
    rx_check("reset_rx");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_dev.md
# uart_dev

Memory-mapped 8N1 serial port that acts as a responder on the core's data bus (`mem_rw`/`d_addr`/`d_data`). It decodes a four-word window at `BASE`, accepts stores into a transmit FIFO and serializes them on `txd`. It also deserializes `rxd` into a holding register that loads can read. It sits beside data memory and is selected purely by address.

## Interface
- `BASE`, 32'h20: word address of register 0; the window is BASE..BASE+3.
- `CLKDIV`, 16: clocks per serial bit; must be an even number and at least 4.
- `DEPTH`, 4: transmit FIFO entries; must be a power of two.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `strobe` in 1: one-cycle pulse qualifying the current access; side effects occur only on a strobed edge.
- `rw` in 1: 1 = store (core drives `data`), 0 = load; same polarity as `mem_rw`.
- `addr` in 32: word address.
- `data` inout 32:
  - Driven only when selected and `rw`=0; the read path is combinational.
  - Otherwise 'bz.
- `txd` out 1: serial output, idles high.
- `rxd` in 1: serial input, asynchronous to `clk`.

## Operation
- Selected when addr[31:2] equals BASE[31:2]. BASE must be 4-aligned.
- Register map, by addr[1:0]:
  - 0 TXDATA: a strobed store pushes data[7:0]; a load returns 0.
  - 1 STATUS, read-only:
    - bit0 = tx FIFO full.
    - bit1 = tx idle (FIFO empty and shifter in IDLE).
    - bit2 = rx_valid.
    - bit3 = rx_overrun.
    - Other bits are 0.
  - 2 RXDATA: a load returns {24'b0, rx_byte}; a strobed load clears rx_valid and rx_overrun.
  - 3: reserved; loads return 0 and stores are ignored.
- TX FIFO:
  - A push while full is dropped silently. Full is the state before the edge, even if a pop occurs on the same edge.
  - A push and a pop on the same edge with the FIFO not full both succeed; the count is unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop into the shifter and go to START.
  - START drives 0; DATA drives 8 bits LSB first; STOP drives 1. Each bit lasts exactly CLKDIV clocks.
  - At the end of STOP: go to START if the FIFO is non-empty (no idle gap between frames), else go to IDLE.
- RX path:
  - `rxd` passes through a 2-flop synchronizer.
  - In idle, a synchronized falling edge starts a wait of CLKDIV/2 clocks. If the line is then high, the start was false; return to idle.
  - Otherwise sample every CLKDIV clocks: 8 data bits (LSB first), then the stop bit.
  - Stop bit = 0 (framing error): discard the byte; rx state is unchanged.
  - Valid stop bit with rx_valid=0: load rx_byte and set rx_valid.
  - Valid stop bit with rx_valid=1: keep the old byte and set rx_overrun.
  - Return to idle right after the stop sample. A new falling edge is accepted immediately.
- Frame completion on the same edge as a strobed RXDATA read: completion wins. The new byte is loaded, rx_valid stays 1 and rx_overrun is cleared.

## Timing
- Reset values:
  - `txd`=1; FIFO empty.
  - TX FSM in IDLE; RX idle.
  - rx_byte=0, rx_valid=0, rx_overrun=0.
  - `data` is 'bz whenever the block is not selected for a load.
- Reset asserted mid-frame: `txd` goes to 1 immediately. FIFO contents and any partial RX byte are lost.
- TX latency:
  - Strobed push at edge k into an empty, idle port: pop at edge k+1, and `txd` falls after edge k+1.
  - A frame lasts 10*CLKDIV clocks.
  - STATUS bit1 returns to 1 on the edge that ends STOP when the FIFO is empty.
- RX latency:
  - rx_valid rises 2 clocks (synchronizer) plus CLKDIV/2 + 9*CLKDIV clocks after the falling edge on `rxd`.
- Load data is valid combinationally in the same cycle that `addr` and `rw` are presented. Clearing side effects take effect at the strobed edge.

## Test plan
- **Single transmit.** CLKDIV=16, BASE=0x20; strobed store 0x55 to 0x20.
  - `txd`=0 from 1 clock after the strobe for 16 clocks.
  - Then bits 1,0,1,0,1,0,1,0 for 16 clocks each, then high.
  - Total frame of 160 clocks; STATUS reads 0x2 afterwards.
- **FIFO fill.** Strobed stores 0x01..0x06 on 6 consecutive edges.
  - 0x01..0x05 accepted and 0x06 dropped.
  - STATUS bit0=1 after the 5th store.
  - Five contiguous frames with no idle gaps.
- **Receive.** Drive an 0xA3 frame on `rxd` at 16 clocks/bit.
  - STATUS bit2=1; a load from 0x22 returns 0x000000A3.
  - After the strobed load, STATUS bit2=0.
- **Overrun.** Receive 0x11 then 0x22 without reading.
  - RXDATA=0x11 and STATUS bits 2 and 3 are 1.
  - A strobed RXDATA load clears both bits.
- **Bad starts.** A `rxd` low pulse of 4 clocks gives no rx_valid. A frame with stop bit 0 is discarded and STATUS is unchanged.
- **Reset and bus.** Assert `reset_n` mid-TX frame.
  - `txd`=1 immediately; STATUS=0x2 after release.
  - `data` is 'bz for addr 0x40, for rw=1, and for addr 0x1F.
